vec_cache_wr_resp_router: RTL and testbench
===========================================

VEC_CACHE_WR_RESP_ROUTER -- requirements
Module: vec_cache_wr_resp_router

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of response directions.
REQ-002 SHALL have parameter DEPTH, default 4: entries per direction response queue; legal range 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_vld  input  1  request valid.
REQ-006 SHALL have port req_rdy  output  1  request ready; a request is accepted when req_vld && req_rdy.
REQ-007 SHALL have port req_pld  input  input_req_pld_t  request payload, carrying opcode, txn_id (including direction_id) and sideband.
REQ-008 SHALL have port v_wresp_vld  output  [WIDTH-1:0]  per-direction write-response valid.
REQ-009 SHALL have port v_wresp_rdy  input  [WIDTH-1:0]  per-direction write-response ready.
REQ-010 SHALL have port v_wresp_pld  output  wr_resp_pld_t [WIDTH-1:0]  per-direction response payload: txn_id, sideband.
REQ-011 SHALL have port v_q_cnt  output  [WIDTH-1:0][$clog2(DEPTH+1)-1:0]  per-direction queue occupancy.
REQ-012 SHALL have port dir_err  output  1  one-cycle pulse on an accepted write whose direction_id >= WIDTH.

Function
REQ-013 SHALL decode direction from req_pld.txn_id.direction_id; only opcode VEC_CACHE_CMD_WRITE produces a response.
REQ-014 SHALL drive req_rdy=1 for non-write opcodes; these are accepted and discarded, with no queue or counter change.
REQ-015 SHALL drive req_rdy = (v_q_cnt[d] != DEPTH) for a write to legal direction d, so a full queue backpressures only writes targeting it.
REQ-016 SHALL NOT let a same-cycle pop on a full queue make req_rdy high; ready is a function of registered count only.
REQ-017 SHALL drive req_rdy=1 for writes with illegal direction_id; on acceptance, drop the request and pulse dir_err on the next cycle.
REQ-018 SHALL push {txn_id, sideband} into queue d on an accepted legal write; latency from acceptance cycle N to v_wresp_vld[d] is 1 cycle, N+1, when the queue was empty.
REQ-019 SHALL drive v_wresp_vld[d] = (v_q_cnt[d] != 0), with v_wresp_pld[d] = queue head; payload SHALL be held stable while vld && !rdy.
REQ-020 SHALL pop queue d on v_wresp_vld[d] && v_wresp_rdy[d].
REQ-021 SHALL preserve per-direction FIFO order; no ordering is implied across directions.
REQ-022 SHALL leave count unchanged on simultaneous push and pop to the same non-empty queue; the head advances and the new entry is appended.
REQ-023 SHALL wrap read and write pointers modulo DEPTH, and SHALL handle DEPTH values that are not a power of two.
REQ-024 SHALL let directions drain independently; a stalled direction SHALL NOT block others.
REQ-025 SHALL keep v_wresp_pld of an empty queue don't-care; benches check pld only when vld=1.

Reset
REQ-026 SHALL, while rst_n=0, force pointers and counts to 0, v_wresp_vld=0, v_q_cnt=0, dir_err=0; req_rdy follows REQ-014..017 with count 0.
REQ-027 SHALL discard all queued responses on reset mid-operation; there is no replay.
REQ-028 SHALL leave queue storage unreset.

Structure
REQ-029 SHALL take input_req_pld_t, wr_resp_pld_t, the VEC_CACHE_CMD_WRITE encoding and the direction_id width from vector_cache_pkg.
REQ-030 SHALL instantiate sub-module vec_cache_wr_resp_fifo (parameters DEPTH and payload type; push/pop, head, cnt) once per direction in a generate loop.
REQ-031 SHALL confine decode, ready muxing and error detection to the top level.

Verification
REQ-032 SHALL cover (WIDTH=4, DEPTH=2) a write to dir 2 with txn_id 0x15 and v_wresp_rdy=4'hF -> v_wresp_vld=4'b0100 for exactly 1 cycle at N+1, pld.txn_id=0x15, v_q_cnt[2] returning 0.
REQ-033 SHALL cover three writes to dir 1 with v_wresp_rdy[1]=0 -> first two accepted, v_q_cnt[1]=2, req_rdy=0 on the third; release rdy -> txn order preserved, third accepted the cycle after the first pop.
REQ-034 SHALL cover dir 0 full and stalled, then a write to dir 3 -> accepted immediately, v_wresp_vld[3]=1 next cycle, dir 0 unchanged.
REQ-035 SHALL cover a read opcode to dir 1, then a write with direction_id=5 -> both accepted, no vld asserted, dir_err pulses once, one cycle after the second.
REQ-036 SHALL cover dir 2 holding 1 entry with push and pop in the same cycle -> v_q_cnt[2] stays 1 and the new head is the pushed txn.
REQ-037 SHALL cover rst_n asserted with 2 entries queued in dir 0 -> v_wresp_vld=0 and v_q_cnt=0 asynchronously, and req_rdy=1 after release.

Source files
------------

// File: rtl/vector_cache_pkg.sv
// Shared vector-cache request/response types and command encodings.
package vector_cache_pkg;

  localparam int unsigned DIR_ID_W    = 3;
  localparam int unsigned TXN_LOCAL_W = 8;
  localparam int unsigned SIDEBAND_W  = 4;

  typedef enum logic [1:0] {
    VEC_CACHE_CMD_READ  = 2'd0,
    VEC_CACHE_CMD_WRITE = 2'd1,
    VEC_CACHE_CMD_FLUSH = 2'd2,
    VEC_CACHE_CMD_INVAL = 2'd3
  } vec_cache_cmd_e;

  typedef struct packed {
    logic [DIR_ID_W-1:0]    direction_id;
    logic [TXN_LOCAL_W-1:0] id;
  } txn_id_t;

  typedef struct packed {
    vec_cache_cmd_e         opcode;
    txn_id_t                txn_id;
    logic [SIDEBAND_W-1:0]  sideband;
  } input_req_pld_t;

  typedef struct packed {
    txn_id_t                txn_id;
    logic [SIDEBAND_W-1:0]  sideband;
  } wr_resp_pld_t;

endpackage

// File: rtl/vec_cache_wr_resp_fifo.sv
// Per-direction response queue; pointers wrap modulo DEPTH so any depth >= 2 works.
module vec_cache_wr_resp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         pld_t = logic
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  pld_t                         push_pld,
  input  logic                         pop,
  output pld_t                         head,
  output logic [$clog2(DEPTH+1)-1:0]   cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  pld_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && (cnt_q != CNT_W'(DEPTH));
  assign do_pop  = pop && (cnt_q != '0);

  always_comb begin
    wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_pld;
  end

  assign head = mem[rd_ptr_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/vec_cache_wr_resp_router.sv
// Routes accepted write requests into per-direction response queues; non-writes are dropped.
module vec_cache_wr_resp_router
  import vector_cache_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    req_vld,
  output logic                                    req_rdy,
  input  input_req_pld_t                          req_pld,
  output logic [WIDTH-1:0]                        v_wresp_vld,
  input  logic [WIDTH-1:0]                        v_wresp_rdy,
  output wr_resp_pld_t [WIDTH-1:0]                v_wresp_pld,
  output logic [WIDTH-1:0][$clog2(DEPTH+1)-1:0]   v_q_cnt,
  output logic                                    dir_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [DIR_ID_W-1:0] dir;
  logic                is_write;
  logic                dir_legal;
  logic                sel_full;
  logic                accept;
  logic                dir_err_q;
  logic [WIDTH-1:0]    full;
  logic [WIDTH-1:0]    push;
  logic [WIDTH-1:0]    pop;
  wr_resp_pld_t        resp_pld;

  assign dir       = req_pld.txn_id.direction_id;
  assign is_write  = (req_pld.opcode == VEC_CACHE_CMD_WRITE);
  assign dir_legal = (32'(dir) < WIDTH);
  assign resp_pld  = '{txn_id: req_pld.txn_id, sideband: req_pld.sideband};

  // Loop select keeps the lookup in range when dir is illegal.
  always_comb begin
    sel_full = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (32'(dir) == i) sel_full = full[i];
    end
  end

  // Ready depends only on registered counts, never on same-cycle pops.
  assign req_rdy = !(is_write && dir_legal && sel_full);
  assign accept  = req_vld && req_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_err_q <= 1'b0;
    else        dir_err_q <= accept && is_write && !dir_legal;
  end

  assign dir_err = dir_err_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_dir
    assign full[g]        = (v_q_cnt[g] == CNT_W'(DEPTH));
    assign v_wresp_vld[g] = (v_q_cnt[g] != '0);
    assign pop[g]         = v_wresp_vld[g] && v_wresp_rdy[g];
    assign push[g]        = accept && is_write && dir_legal && (32'(dir) == g);

    vec_cache_wr_resp_fifo #(
      .DEPTH (DEPTH),
      .pld_t (wr_resp_pld_t)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push[g]),
      .push_pld (resp_pld),
      .pop      (pop[g]),
      .head     (v_wresp_pld[g]),
      .cnt      (v_q_cnt[g])
    );
  end

endmodule

// File: tb/tb_vec_cache_wr_resp_router.sv
// Scoreboard bench: driver queues expected responses, monitor checks every handshake.
module tb_vec_cache_wr_resp_router;
  import vector_cache_pkg::*;

  localparam int unsigned W = 4;
  localparam int unsigned D = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  req_vld;
  logic                  req_rdy;
  input_req_pld_t        req_pld;
  logic [W-1:0]          v_wresp_vld;
  logic [W-1:0]          v_wresp_rdy;
  wr_resp_pld_t [W-1:0]  v_wresp_pld;
  logic [W-1:0][1:0]     v_q_cnt;
  logic                  dir_err;

  int tests = 0;
  int fails = 0;
  wr_resp_pld_t exp_q [W][$];

  vec_cache_wr_resp_router #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .req_pld     (req_pld),
    .v_wresp_vld (v_wresp_vld),
    .v_wresp_rdy (v_wresp_rdy),
    .v_wresp_pld (v_wresp_pld),
    .v_q_cnt     (v_q_cnt),
    .dir_err     (dir_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the falling edge pops at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < W; d++) begin
        if (v_wresp_vld[d] && v_wresp_rdy[d]) begin
          tests++;
          if (exp_q[d].size() == 0) begin
            fails++;
            $display("FAIL resp_dir%0d: got %0h expected none", d, v_wresp_pld[d]);
          end else begin
            wr_resp_pld_t e;
            e = exp_q[d].pop_front();
            if (v_wresp_pld[d] !== e) begin
              fails++;
              $display("FAIL resp_dir%0d: got %0h expected %0h", d, v_wresp_pld[d], e);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input vec_cache_cmd_e op, input int dir, input logic [7:0] id,
                       input logic [3:0] sb, output int waited);
    wr_resp_pld_t e;
    req_vld                    = 1'b1;
    req_pld.opcode             = op;
    req_pld.txn_id.direction_id = 3'(dir);
    req_pld.txn_id.id          = id;
    req_pld.sideband           = sb;
    waited = 0;
    @(negedge clk);
    while (!req_rdy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_rdy) begin
      chk("issue_timeout", 32'(waited), 32'd0);
    end else if (op == VEC_CACHE_CMD_WRITE && dir < W) begin
      e.txn_id.direction_id = 3'(dir);
      e.txn_id.id           = id;
      e.sideband            = sb;
      exp_q[dir].push_back(e);
    end
    step();
    req_vld = 1'b0;
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    req_vld     = 1'b0;
    req_pld     = '0;
    req_pld.opcode = VEC_CACHE_CMD_WRITE;
    v_wresp_rdy = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_vld", 32'(v_wresp_vld), 32'h0);
    chk("rst_cnt", 32'(v_q_cnt), 32'h0);
    chk("rst_dir_err", 32'(dir_err), 32'h0);
    chk("rst_req_rdy", 32'(req_rdy), 32'h1);
    step();
    rst_n = 1'b1;
    step();

    // Single write, 1-cycle latency, immediate drain.
    issue(VEC_CACHE_CMD_WRITE, 2, 8'h15, 4'h3, n);
    chk("lat_vld", 32'(v_wresp_vld), 32'h4);
    chk("lat_id", 32'(v_wresp_pld[2].txn_id.id), 32'h15);
    chk("lat_cnt2", 32'(v_q_cnt[2]), 32'h1);
    step();
    chk("lat_vld_after", 32'(v_wresp_vld), 32'h0);
    chk("lat_cnt2_after", 32'(v_q_cnt[2]), 32'h0);

    // Backpressure on a full direction, ordering on release.
    v_wresp_rdy = 4'b1101;
    issue(VEC_CACHE_CMD_WRITE, 1, 8'h21, 4'h1, n);
    issue(VEC_CACHE_CMD_WRITE, 1, 8'h22, 4'h2, n);
    chk("bp_cnt1_full", 32'(v_q_cnt[1]), 32'h2);
    req_vld = 1'b1;
    req_pld.opcode = VEC_CACHE_CMD_WRITE;
    req_pld.txn_id.direction_id = 3'd1;
    req_pld.txn_id.id = 8'h23;
    req_pld.sideband = 4'h3;
    @(negedge clk);
    chk("bp_rdy_low", 32'(req_rdy), 32'h0);
    step();
    v_wresp_rdy = 4'hF;
    @(negedge clk);
    chk("bp_rdy_low_during_pop", 32'(req_rdy), 32'h0);
    step();
    @(negedge clk);
    chk("bp_rdy_after_pop", 32'(req_rdy), 32'h1);
    exp_q[1].push_back('{txn_id: '{direction_id: 3'd1, id: 8'h23}, sideband: 4'h3});
    step();
    req_vld = 1'b0;
    chk("bp_cnt1_third", 32'(v_q_cnt[1]), 32'h1);
    step();
    chk("bp_cnt1_drained", 32'(v_q_cnt[1]), 32'h0);

    // Stalled full dir 0 must not block dir 3.
    v_wresp_rdy = 4'b1110;
    issue(VEC_CACHE_CMD_WRITE, 0, 8'h31, 4'h4, n);
    issue(VEC_CACHE_CMD_WRITE, 0, 8'h32, 4'h5, n);
    issue(VEC_CACHE_CMD_WRITE, 3, 8'h41, 4'h6, n);
    chk("indep_wait", 32'(n), 32'h0);
    chk("indep_vld", 32'(v_wresp_vld), 32'h9);
    chk("indep_cnt0", 32'(v_q_cnt[0]), 32'h2);
    chk("indep_head0", 32'(v_wresp_pld[0].txn_id.id), 32'h31);
    v_wresp_rdy = 4'hF;
    repeat (3) step();
    chk("indep_drained", 32'(v_q_cnt), 32'h0);

    // Read is discarded; illegal direction pulses dir_err once.
    issue(VEC_CACHE_CMD_READ, 1, 8'h51, 4'h7, n);
    chk("rd_wait", 32'(n), 32'h0);
    chk("rd_cnt", 32'(v_q_cnt), 32'h0);
    chk("rd_dir_err", 32'(dir_err), 32'h0);
    issue(VEC_CACHE_CMD_WRITE, 5, 8'h52, 4'h8, n);
    chk("err_wait", 32'(n), 32'h0);
    chk("err_pulse", 32'(dir_err), 32'h1);
    chk("err_vld", 32'(v_wresp_vld), 32'h0);
    step();
    chk("err_pulse_end", 32'(dir_err), 32'h0);
    chk("err_cnt", 32'(v_q_cnt), 32'h0);

    // Simultaneous push and pop on a one-entry queue.
    v_wresp_rdy = 4'b1011;
    issue(VEC_CACHE_CMD_WRITE, 2, 8'h61, 4'h9, n);
    chk("pp_cnt_pre", 32'(v_q_cnt[2]), 32'h1);
    v_wresp_rdy = 4'hF;
    issue(VEC_CACHE_CMD_WRITE, 2, 8'h62, 4'hA, n);
    chk("pp_cnt", 32'(v_q_cnt[2]), 32'h1);
    chk("pp_head", 32'(v_wresp_pld[2].txn_id.id), 32'h62);
    step();
    chk("pp_cnt_drained", 32'(v_q_cnt[2]), 32'h0);

    // Asynchronous reset with dir 0 holding two entries.
    v_wresp_rdy = 4'b1110;
    issue(VEC_CACHE_CMD_WRITE, 0, 8'h71, 4'hB, n);
    issue(VEC_CACHE_CMD_WRITE, 0, 8'h72, 4'hC, n);
    chk("ar_cnt_pre", 32'(v_q_cnt[0]), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_vld", 32'(v_wresp_vld), 32'h0);
    chk("ar_cnt", 32'(v_q_cnt), 32'h0);
    exp_q[0].delete();
    req_pld.opcode = VEC_CACHE_CMD_WRITE;
    req_pld.txn_id.direction_id = 3'd0;
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_req_rdy", 32'(req_rdy), 32'h1);
    chk("ar_vld_post", 32'(v_wresp_vld), 32'h0);

    v_wresp_rdy = 4'hF;
    repeat (4) step();
    for (int d = 0; d < W; d++) chk($sformatf("sb_empty_dir%0d", d), 32'(exp_q[d].size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
